// File: rtl/sp_ram_initiator_pkg.sv
// sp_ram_initiator_pkg: shared response type, FSM states and word-offset constant
package sp_ram_initiator_pkg;
  localparam int WORD_OFFSET = 2;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// sp_ram_rsp_fifo: power-of-two response FIFO with occupancy count
module sp_ram_rsp_fifo
  import sp_ram_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  rsp_t                     din,
  output rsp_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  rsp_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/sp_ram_initiator.sv
// sp_ram_initiator: front-side request to single-port RAM bridge with in-order buffered responses
// Optional misaligned-access error reporting enabled by SP_RAM_INITIATOR_ALIGN_CHECK_EN.
module sp_ram_initiator
  import sp_ram_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [31:0]           rdata_o,
  output logic                  rerr_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  state_t          state;
  logic            we_q, err_q, accept, mis, push, pop, full, empty;
  logic [CW-1:0]   count;
  rsp_t            head, din;
`ifdef SP_RAM_INITIATOR_ALIGN_CHECK_EN
  assign mis = addr_i[WORD_OFFSET-1:0] != '0;
`else
  assign mis = 1'b0;
`endif
  // the in-flight request counts against capacity so a push can never hit a full FIFO
  assign gnt_o       = !rst_i && (int'(count) + int'(state == WAIT) < RSP_DEPTH);
  assign accept      = req_i && gnt_o;
  assign mem_en_o    = accept && !mis;
  assign mem_we_o    = mem_en_o && we_i;
  assign mem_addr_o  = addr_i & ~ADDR_WIDTH'((1 << WORD_OFFSET) - 1);
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= accept ? WAIT : IDLE;
      we_q  <= we_i;
      err_q <= mis;
    end
  end
  assign push      = state == WAIT;
  assign din.rdata = (we_q || err_q) ? '0 : mem_rdata_i;
  assign din.err   = err_q;
  assign rvalid_o  = !empty && !rst_i;
  assign pop       = rvalid_o && rready_i;
  assign rdata_o   = rvalid_o ? head.rdata : '0;
  assign rerr_o    = rvalid_o && head.err;
  sp_ram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk_i) if (!rst_i) assert (!(push && full));
endmodule
